mdu: RTL and testbench
======================

MDU -- requirements
Module: mdu

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, named clk and reset.
REQ-002 clk  input  1  rising-edge clock for all state.
REQ-003 reset  input  1  asynchronous, active-high; clears all state immediately.
REQ-004 start  input  1  one-cycle request to begin the operation selected by MDUop.
REQ-005 MDUop  input  3  operation: 000 multu, 001 mult, 010 divu, 011 div; 1xx reserved.
REQ-006 c_HIWE  input  1  mthi: write A into HI.
REQ-007 c_LOWE  input  1  mtlo: write A into LO.
REQ-008 A  input  32  operand rs (multiplicand or dividend; mthi/mtlo data).
REQ-009 B  input  32  operand rt (multiplier or divisor).
REQ-010 busy  output  1  operation in flight; the decode stage stalls any MD instruction while busy or start is high.
REQ-011 HI  output  32  HI register, read by mfhi.
REQ-012 LO  output  32  LO register, read by mflo.

Function
REQ-013 The block SHALL be a two-state machine: IDLE and RUN, with a 4-bit down-counter cnt.
REQ-014 IDLE, start=1, MDUop[2]=0: SHALL latch A, B and MDUop, set cnt to 5 (mult/multu) or 10 (div/divu), and enter RUN.
REQ-015 IDLE, start=1, MDUop[2]=1: SHALL be ignored; state, HI and LO unchanged.
REQ-016 busy SHALL be 1 exactly while in RUN.
- Start sampled at edge T -> busy high from after edge T for 5 (mult) or 10 (div) cycles.
REQ-017 RUN: cnt SHALL decrement each edge; on the edge where cnt goes 1->0, HI/LO SHALL update, busy SHALL fall and the state SHALL return to IDLE.
- HI/LO therefore change in the same cycle busy drops.
REQ-018 During RUN, HI and LO outputs SHALL keep their pre-operation values; no partial results are visible.
REQ-019 multu: {HI,LO} SHALL equal the 64-bit unsigned product A*B.
REQ-020 mult: {HI,LO} SHALL equal the 64-bit two's-complement product.
REQ-021 divu: LO SHALL equal the unsigned quotient and HI the unsigned remainder.
REQ-022 div: LO SHALL equal the signed quotient truncated toward zero, and HI the remainder, which takes the sign of the dividend.
REQ-023 div with A=0x80000000, B=0xFFFFFFFF: SHALL give LO=0x80000000, HI=0.
REQ-024 div or divu with B=0: SHALL still run 10 busy cycles and then leave HI and LO unchanged.
REQ-025 IDLE, c_HIWE=1: HI SHALL take A at the next edge; IDLE, c_LOWE=1: LO SHALL take A at the next edge; both set: both written.
REQ-026 start=1 together with c_HIWE or c_LOWE in IDLE: start SHALL win and the mthi/mtlo write SHALL be dropped.
REQ-027 While busy=1: start, c_HIWE and c_LOWE SHALL be ignored.
REQ-028 Operands latched at start SHALL be used for the whole operation, regardless of A/B changes during RUN.
REQ-029 Back-to-back ops: start may be accepted in the first cycle after busy falls.
REQ-030 The block SHALL hold no combinational path from any input to busy, HI or LO.

Reset
REQ-031 reset=1 SHALL immediately force state IDLE, cnt=0, busy=0, HI=0, LO=0, and clear the latched operands.
REQ-032 reset asserted during RUN SHALL abort the operation with no HI/LO commit; after deassertion the block is IDLE and accepts start on the next edge.
REQ-033 start asserted in the same cycle reset deasserts SHALL be sampled normally at the following edge.

Verification
REQ-034 multu A=0xFFFFFFFF, B=2, start 1 cycle -> busy=1 for exactly 5 cycles; then HI=0x00000001, LO=0xFFFFFFFE.
REQ-035 mult A=-3 (0xFFFFFFFD), B=7 -> after 5 busy cycles HI=0xFFFFFFFF, LO=0xFFFFFFEB.
REQ-036 Divides -> after 10 busy cycles:
- div A=-7, B=2: LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- divu A=7, B=2: LO=3, HI=1.
- divu with B=0: HI/LO unchanged.
REQ-037 Ignored writes:
- mthi A=0x12345678 in IDLE -> HI=0x12345678 next cycle.
- mtlo issued while busy -> LO unaffected.
- start+c_HIWE together -> HI gets the product only.
REQ-038 Reset mid-op: div started, reset pulsed at busy cycle 4 -> busy=0, HI=LO=0 immediately; no later commit; new multu accepted right after.
REQ-039 Ignored requests:
- start with MDUop=100 -> busy stays 0, HI/LO unchanged.
- second start during RUN -> first result only, busy length unchanged.

Source files
------------

// File: rtl/mdu.sv
// Multiply/divide unit: fixed-latency multu/mult (5 cycles) and divu/div (10 cycles)
// with HI/LO result registers and mthi/mtlo writes. All outputs come from registers.
module mdu (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  MDUop,
    input  logic        c_HIWE,
    input  logic        c_LOWE,
    input  logic [31:0] A,
    input  logic [31:0] B,
    output logic        busy,
    output logic [31:0] HI,
    output logic [31:0] LO
);

    typedef enum logic {StIdle, StRun} state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] a_q, a_d, b_q, b_d;
    logic [1:0]  op_q, op_d;
    logic [31:0] hi_q, hi_d, lo_q, lo_d;

    logic [63:0] a_ext, b_ext, prod;
    logic [31:0] a_mag, b_mag, q_mag, r_mag, quot, rem;
    logic        is_signed, is_div, div_by_zero;

    // Result datapath, computed only from the operands latched at start.
    always_comb begin
        is_signed   = op_q[0];
        is_div      = op_q[1];
        div_by_zero = (b_q == 32'd0);
        a_ext = {{32{is_signed & a_q[31]}}, a_q};
        b_ext = {{32{is_signed & b_q[31]}}, b_q};
        prod  = a_ext * b_ext;
        // Signed divide works on magnitudes so 0x80000000 / -1 wraps cleanly.
        a_mag = (is_signed && a_q[31]) ? (~a_q + 32'd1) : a_q;
        b_mag = (is_signed && b_q[31]) ? (~b_q + 32'd1) : b_q;
        q_mag = 32'd0;
        r_mag = 32'd0;
        if (!div_by_zero) begin
            q_mag = a_mag / b_mag;
            r_mag = a_mag % b_mag;
        end
        quot = (is_signed && (a_q[31] ^ b_q[31])) ? (~q_mag + 32'd1) : q_mag;
        rem  = (is_signed && a_q[31]) ? (~r_mag + 32'd1) : r_mag;
    end

    // Next-state: accept start or mthi/mtlo in idle, count down and commit in run.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        a_d     = a_q;
        b_d     = b_q;
        op_d    = op_q;
        hi_d    = hi_q;
        lo_d    = lo_q;
        unique case (state_q)
            StIdle: begin
                if (start && !MDUop[2]) begin
                    // start takes priority; a simultaneous mthi/mtlo is dropped
                    a_d     = A;
                    b_d     = B;
                    op_d    = MDUop[1:0];
                    cnt_d   = MDUop[1] ? 4'd10 : 4'd5;
                    state_d = StRun;
                end else if (!start) begin
                    if (c_HIWE) hi_d = A;
                    if (c_LOWE) lo_d = A;
                end
            end
            StRun: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) begin
                    state_d = StIdle;
                    if (!is_div) begin
                        hi_d = prod[63:32];
                        lo_d = prod[31:0];
                    end else if (!div_by_zero) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and result registers with asynchronous clear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            cnt_q   <= 4'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            op_q    <= 2'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            a_q     <= a_d;
            b_q     <= b_d;
            op_q    <= op_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // Outputs straight from registers.
    always_comb begin
        busy = (state_q == StRun);
        HI   = hi_q;
        LO   = lo_q;
    end

endmodule

// File: tb/tb_mdu.sv
// Self-checking bench for mdu: directed vectors plus randomized ops against an
// arithmetic reference model.
module tb_mdu;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [2:0]  MDUop = 3'd0;
    logic        c_HIWE = 1'b0;
    logic        c_LOWE = 1'b0;
    logic [31:0] A = 32'd0;
    logic [31:0] B = 32'd0;
    logic        busy;
    logic [31:0] HI, LO;

    int total = 0;
    int bad = 0;
    logic [31:0] m_hi = 32'd0;
    logic [31:0] m_lo = 32'd0;

    mdu dut (
        .clk    (clk),
        .reset  (reset),
        .start  (start),
        .MDUop  (MDUop),
        .c_HIWE (c_HIWE),
        .c_LOWE (c_LOWE),
        .A      (A),
        .B      (B),
        .busy   (busy),
        .HI     (HI),
        .LO     (LO)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Reference: {HI,LO} after an op, from plain 64-bit arithmetic.
    function automatic logic [63:0] ref_op(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b, input logic [31:0] h,
                                           input logic [31:0] l);
        longint unsigned ua, ub;
        longint          sa, sb, sq, sr;
        ua = {32'd0, a};
        ub = {32'd0, b};
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        case (op)
            2'd0: return ua * ub;
            2'd1: return sa * sb;
            2'd2: begin
                if (b == 32'd0) return {h, l};
                return {32'(ua % ub), 32'(ua / ub)};
            end
            default: begin
                if (b == 32'd0) return {h, l};
                sq = sa / sb;
                sr = sa % sb;
                return {32'(sr), 32'(sq)};
            end
        endcase
    endfunction

    // Issue one op, scramble A/B during the run, measure busy length and whether HI/LO held.
    task automatic issue_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                            output int cycles, output bit held);
        logic [31:0] h0, l0;
        h0 = HI;
        l0 = LO;
        held = 1'b1;
        MDUop = op;
        A = a;
        B = b;
        start = 1'b1;
        tick();
        start = 1'b0;
        A = $urandom;
        B = $urandom;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin
            if (HI !== h0 || LO !== l0) held = 1'b0;
            cycles++;
            tick();
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        tick();
        tick();
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (HI !== 32'd0) begin bad++; $display("FAIL reset_hi got=%h exp=0", HI); end
        total++; if (LO !== 32'd0) begin bad++; $display("FAIL reset_lo got=%h exp=0", LO); end
        reset = 1'b0;
        m_hi = 32'd0;
        m_lo = 32'd0;
        tick();
    endtask

    task automatic test_directed();
        logic [2:0]  ops  [6] = '{3'd0, 3'd1, 3'd3, 3'd2, 3'd2, 3'd3};
        logic [31:0] as   [6] = '{32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFF9, 32'd7, 32'd9,
                                  32'h80000000};
        logic [31:0] bs   [6] = '{32'd2, 32'd7, 32'd2, 32'd2, 32'd0, 32'hFFFFFFFF};
        int          lens [6] = '{5, 5, 10, 10, 10, 10};
        logic [31:0] ehi  [6] = '{32'h1, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd1, 32'd0};
        logic [31:0] elo  [6] = '{32'hFFFFFFFE, 32'hFFFFFFEB, 32'hFFFFFFFD, 32'd3, 32'd3,
                                  32'h80000000};
        int cycles;
        bit held;
        for (int i = 0; i < 6; i++) begin
            issue_op(ops[i], as[i], bs[i], cycles, held);
            total++; if (cycles != lens[i]) begin bad++;
                $display("FAIL dir%0d_len got=%0d exp=%0d", i, cycles, lens[i]); end
            total++; if (!held) begin bad++; $display("FAIL dir%0d_hold got=changed exp=held", i); end
            total++; if (HI !== ehi[i]) begin bad++;
                $display("FAIL dir%0d_hi got=%h exp=%h", i, HI, ehi[i]); end
            total++; if (LO !== elo[i]) begin bad++;
                $display("FAIL dir%0d_lo got=%h exp=%h", i, LO, elo[i]); end
        end
        m_hi = HI === 32'd0 ? 32'd0 : 32'd0;
        m_hi = 32'd0;
        m_lo = 32'h80000000;
    endtask

    task automatic test_mthi_mtlo();
        int cycles;
        bit held;
        logic [63:0] r;
        c_HIWE = 1'b1; A = 32'h12345678; tick(); c_HIWE = 1'b0;
        total++; if (HI !== 32'h12345678) begin bad++;
            $display("FAIL mthi got=%h exp=12345678", HI); end
        c_LOWE = 1'b1; A = 32'hCAFEF00D; tick(); c_LOWE = 1'b0;
        total++; if (LO !== 32'hCAFEF00D) begin bad++;
            $display("FAIL mtlo got=%h exp=cafef00d", LO); end
        c_HIWE = 1'b1; c_LOWE = 1'b1; A = 32'h0BADBEEF; tick(); c_HIWE = 1'b0; c_LOWE = 1'b0;
        total++; if (HI !== 32'h0BADBEEF || LO !== 32'h0BADBEEF) begin bad++;
            $display("FAIL mthi_mtlo_both got=%h/%h exp=0badbeef", HI, LO); end
        m_hi = 32'h0BADBEEF; m_lo = 32'h0BADBEEF;
        // mtlo while busy is ignored
        MDUop = 3'd0; A = 32'd1000; B = 32'd3; start = 1'b1; tick(); start = 1'b0;
        c_LOWE = 1'b1; A = 32'h55555555;
        for (int i = 0; i < 20 && busy === 1'b1; i++) tick();
        c_LOWE = 1'b0;
        total++; if (LO !== 32'd3000 || HI !== 32'd0) begin bad++;
            $display("FAIL mtlo_busy got=%h/%h exp=0/00000bb8", HI, LO); end
        // start with mthi in the same cycle: start wins
        r = ref_op(2'd1, 32'hFFFF0000, 32'h00030000, HI, LO);
        MDUop = 3'd1; A = 32'hFFFF0000; B = 32'h00030000; c_HIWE = 1'b1; start = 1'b1;
        tick();
        start = 1'b0; c_HIWE = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin cycles++; tick(); end
        total++; if (HI !== r[63:32] || LO !== r[31:0]) begin bad++;
            $display("FAIL start_beats_mthi got=%h%h exp=%h", HI, LO, r); end
        m_hi = r[63:32]; m_lo = r[31:0];
        held = 1'b1;
    endtask

    task automatic test_reserved();
        int cycles;
        bit held;
        logic [31:0] h0, l0;
        h0 = HI; l0 = LO;
        MDUop = 3'b100; A = 32'd5; B = 32'd6; start = 1'b1; tick(); start = 1'b0;
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reserved_busy got=%b exp=0", busy); end
        tick(); tick();
        total++; if (HI !== h0 || LO !== l0) begin bad++;
            $display("FAIL reserved_hilo got=%h/%h exp=%h/%h", HI, LO, h0, l0); end
        // second start during run is ignored
        MDUop = 3'd2; A = 32'd100; B = 32'd7; start = 1'b1; tick();
        MDUop = 3'd0; A = 32'd9; B = 32'd9; tick(); start = 1'b0;
        cycles = 1;
        while (busy === 1'b1 && cycles < 40) begin cycles++; tick(); end
        total++; if (cycles != 10) begin bad++;
            $display("FAIL second_start_len got=%0d exp=10", cycles); end
        total++; if (LO !== 32'd14 || HI !== 32'd2) begin bad++;
            $display("FAIL second_start_res got=%h/%h exp=2/e", HI, LO); end
        m_hi = 32'd2; m_lo = 32'd14;
        held = 1'b1;
    endtask

    task automatic test_reset_mid_op();
        int cycles;
        bit held;
        MDUop = 3'd3; A = 32'd77; B = 32'd5; start = 1'b1; tick(); start = 1'b0;
        tick(); tick(); tick();
        #2 reset = 1'b1;
        #1;
        total++; if (busy !== 1'b0 || HI !== 32'd0 || LO !== 32'd0) begin bad++;
            $display("FAIL reset_mid got=%b %h/%h exp=0 0/0", busy, HI, LO); end
        tick();
        reset = 1'b0;
        for (int i = 0; i < 12; i++) tick();
        total++; if (HI !== 32'd0 || LO !== 32'd0) begin bad++;
            $display("FAIL reset_no_commit got=%h/%h exp=0/0", HI, LO); end
        issue_op(3'd0, 32'd6, 32'd7, cycles, held);
        total++; if (cycles != 5 || LO !== 32'd42 || HI !== 32'd0) begin bad++;
            $display("FAIL after_reset_op got=%0d %h/%h exp=5 0/2a", cycles, HI, LO); end
        // start in the same cycle reset deasserts is sampled at the next edge
        @(negedge clk); reset = 1'b1;
        @(negedge clk); reset = 1'b0;
        MDUop = 3'd0; A = 32'd3; B = 32'd4; start = 1'b1;
        tick(); start = 1'b0;
        cycles = 0;
        while (busy === 1'b1 && cycles < 40) begin cycles++; tick(); end
        total++; if (cycles != 5 || LO !== 32'd12) begin bad++;
            $display("FAIL start_at_deassert got=%0d %h exp=5 c", cycles, LO); end
        m_hi = 32'd0; m_lo = 32'd12;
    endtask

    task automatic test_back_to_back();
        int cycles;
        bit held;
        logic [2:0]  op;
        logic [31:0] a, b;
        logic [63:0] r;
        for (int i = 0; i < 40; i++) begin
            op = 3'($urandom_range(0, 3));
            a  = $urandom;
            b  = ($urandom_range(0, 7) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) b = b & 32'hFF;
            r = ref_op(op[1:0], a, b, m_hi, m_lo);
            issue_op(op, a, b, cycles, held);
            total++; if (cycles != (op[1] ? 10 : 5)) begin bad++;
                $display("FAIL rnd%0d_len op=%0d got=%0d exp=%0d", i, op, cycles, op[1] ? 10 : 5);
            end
            total++; if (!held) begin bad++; $display("FAIL rnd%0d_hold got=changed exp=held", i); end
            total++; if ({HI, LO} !== r) begin bad++;
                $display("FAIL rnd%0d_res op=%0d a=%h b=%h got=%h%h exp=%h", i, op, a, b, HI, LO, r);
            end
            m_hi = r[63:32];
            m_lo = r[31:0];
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_mthi_mtlo();
        test_reserved();
        test_reset_mid_op();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout got=running exp=finished");
        $fatal(1);
    end

endmodule
